// File: rtl/ddr_vga_pkg.sv
// Shared VGA timing defaults, colour field layout and pixel types
// for the DDR game display scan path.
package ddr_vga_pkg;

  localparam int CNT_W = 11;
  localparam int RGB_W = 8;
  localparam int DIV_W = 4;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int R_LSB = 0;
  localparam int R_MSB = 2;
  localparam int G_LSB = 3;
  localparam int G_MSB = 5;
  localparam int B_LSB = 6;
  localparam int B_MSB = 7;

  localparam logic [RGB_W-1:0] COLOR_NULL = 8'h00;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } vga_rgb_t;

  function automatic vga_rgb_t split_rgb(
    input logic [RGB_W-1:0] c
  );
    vga_rgb_t p;
    p.r = c[R_MSB:R_LSB];
    p.g = c[G_MSB:G_LSB];
    p.b = c[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// Scan bus between the VGA timing stage and the pixel renderer,
// plus the VGA pin bundle.
interface vga_scan_driver_if;
  import ddr_vga_pkg::*;

  logic [RGB_W-1:0] rgb_in;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             pix_en;
  logic             frame_start;
  logic             active;
  logic             hsync;
  logic             vsync;
  logic [2:0]       vga_r;
  logic [2:0]       vga_g;
  logic [1:0]       vga_b;

  modport master (
    input  rgb_in,
    output x, y, pix_en, frame_start, active,
    output hsync, vsync, vga_r, vga_g, vga_b
  );

  modport slave (
    output rgb_in,
    input  x, y, pix_en, frame_start, active,
    input  hsync, vsync, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from MAX back to zero;
// wrap flags the terminal count.
module wrap_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = (count == WIDTH'(MAX));

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= wrap ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: scan coordinates, sync pulses,
// frame tick and blanked colour output stage.
module vga_scan_driver
  import ddr_vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input logic              clk,
  input logic              reset,
  vga_scan_driver_if.master vga
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  logic [DIV_W-1:0] div;
  logic             div_wrap;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             x_wrap;
  logic             y_wrap;
  logic             y_en;
  logic             pix_en;
  logic             active;
  logic             h_win;
  logic             v_win;
  logic             hsync;
  logic             vsync;
  vga_rgb_t         pix_q;
  logic             unused_div;

  wrap_counter #(
    .WIDTH (DIV_W),
    .MAX   (CLK_DIV - 1)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (div),
    .wrap  (div_wrap)
  );

  wrap_counter #(
    .WIDTH (CNT_W),
    .MAX   (H_TOT - 1)
  ) u_h (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .count (x),
    .wrap  (x_wrap)
  );

  assign y_en = pix_en & x_wrap;

  wrap_counter #(
    .WIDTH (CNT_W),
    .MAX   (V_TOT - 1)
  ) u_v (
    .clk   (clk),
    .reset (reset),
    .en    (y_en),
    .count (y),
    .wrap  (y_wrap)
  );

  assign unused_div = ^div;

  assign active = (x < CNT_W'(H_ACTIVE))
               && (y < CNT_W'(V_ACTIVE));
  assign h_win  = (x >= CNT_W'(HS_BEG))
               && (x <  CNT_W'(HS_END));
  assign v_win  = (y >= CNT_W'(VS_BEG))
               && (y <  CNT_W'(VS_END));

  // The pixel being left on this strobe is sampled here, so colour
  // and sync land together one pixel period behind x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en <= 1'b0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
      pix_q  <= split_rgb(COLOR_NULL);
    end else begin
      pix_en <= div_wrap;
      if (pix_en) begin
        pix_q <= active ? split_rgb(vga.rgb_in)
                        : split_rgb(COLOR_NULL);
        hsync <= h_win ? SYNC_POL : ~SYNC_POL;
        vsync <= v_win ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign vga.x           = x;
  assign vga.y           = y;
  assign vga.pix_en      = pix_en;
  assign vga.frame_start = y_en & y_wrap;
  assign vga.active      = active;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.vga_r       = pix_q.r;
  assign vga.vga_g       = pix_q.g;
  assign vga.vga_b       = pix_q.b;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a shrunken raster: one CLK_DIV=4 and
// one CLK_DIV=1 instance, checkpoint table plus colour scoreboard.
module tb_vga_scan_driver;
  import ddr_vga_pkg::*;

  localparam int D  = 4;
  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 4;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_scan_driver_if if_a();
  vga_scan_driver_if if_b();

  vga_scan_driver #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS),
    .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS),
    .V_BP(VB), .SYNC_POL(1'b0)
  ) dut_a (.clk(clk), .reset(reset), .vga(if_a));

  vga_scan_driver #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS),
    .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS),
    .V_BP(VB), .SYNC_POL(1'b0)
  ) dut_b (.clk(clk), .reset(reset), .vga(if_b));

  int checks = 0;
  int failures = 0;
  int k = 0;
  int abs_cyc = 0;
  bit started = 1'b0;
  bit mode_ff = 1'b0;
  int fs_a = 0;
  int fs_b = 0;
  int last_fs_a = 0;
  int last_fs_b = 0;

  typedef struct {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
  } out_t;

  out_t sbq[$];

  typedef struct {
    int         k;
    int         x;
    int         y;
    bit         pe;
    bit         fs;
    bit         hs;
    bit         vs;
    bit         chk_c;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } vec_t;

  function automatic logic [7:0] render(input int px,
                                        input int py);
    if (mode_ff)
      return 8'hFF;
    return 8'(px * 7 + py * 13 + 1);
  endfunction

  // cycles since reset was last sampled
  initial begin
    forever begin
      @(posedge clk);
      abs_cyc++;
      if (reset) begin
        k = 0;
        started = 1'b1;
      end else begin
        k++;
      end
    end
  end

  // closed-form model of instance A plus colour scoreboard
  initial begin
    int   p, mx, my;
    bit   mpe, mfs, mact;
    logic [7:0] c;
    out_t cur, e;
    bit   pend;
    pend = 1'b0;
    cur = '{3'd0, 3'd0, 2'd0, 1'b1, 1'b1};
    if_a.rgb_in = 8'h00;
    forever begin
      @(negedge clk);
      if (started) begin
        p    = (k >= 1) ? (k - 1) / D : 0;
        mx   = p % HT;
        my   = (p / HT) % VT;
        mpe  = (k >= D) && (k % D == 0);
        mfs  = mpe && mx == HT - 1 && my == VT - 1;
        mact = (mx < HA) && (my < VA);
        if (k == 0) begin
          sbq.delete();
          pend = 1'b0;
          cur = '{3'd0, 3'd0, 2'd0, 1'b1, 1'b1};
          last_fs_a = abs_cyc;
          last_fs_b = abs_cyc;
        end else if (pend && sbq.size() > 0) begin
          cur = sbq.pop_front();
          pend = 1'b0;
        end
        checks++;
        if (if_a.x !== 11'(mx) || if_a.y !== 11'(my)
            || if_a.pix_en !== mpe
            || if_a.frame_start !== mfs
            || if_a.active !== mact
            || if_a.vga_r !== cur.r || if_a.vga_g !== cur.g
            || if_a.vga_b !== cur.b
            || if_a.hsync !== cur.hs
            || if_a.vsync !== cur.vs) begin
          failures++;
          $display("FAIL scan_a k=%0d got x=%0d y=%0d pe=%b fs=%b act=%b rgb=%0d/%0d/%0d hs=%b vs=%b want x=%0d y=%0d pe=%b fs=%b act=%b rgb=%0d/%0d/%0d hs=%b vs=%b",
                   k, if_a.x, if_a.y, if_a.pix_en,
                   if_a.frame_start, if_a.active, if_a.vga_r,
                   if_a.vga_g, if_a.vga_b, if_a.hsync,
                   if_a.vsync, mx, my, mpe, mfs, mact, cur.r,
                   cur.g, cur.b, cur.hs, cur.vs);
        end
        c = render(mx, my);
        if_a.rgb_in = c;
        if (mpe) begin
          e.r  = mact ? c[2:0] : 3'd0;
          e.g  = mact ? c[5:3] : 3'd0;
          e.b  = mact ? c[7:6] : 2'd0;
          e.hs = (mx >= HA + HF && mx < HA + HF + HS) ? 1'b0
                                                        : 1'b1;
          e.vs = (my >= VA + VF && my < VA + VF + VS) ? 1'b0
                                                        : 1'b1;
          sbq.push_back(e);
          pend = 1'b1;
        end
        if (if_a.frame_start === 1'b1) begin
          fs_a++;
          checks++;
          if (abs_cyc - last_fs_a != D * HT * VT) begin
            failures++;
            $display("FAIL fs_period_a got=%0d want=%0d",
                     abs_cyc - last_fs_a, D * HT * VT);
          end
          last_fs_a = abs_cyc;
        end
        // instance B: one pixel per clk
        checks++;
        if (if_b.pix_en !== (k >= 1)
            || if_b.x !== 11'((k >= 1) ? (k - 1) % HT : 0)
            || if_b.y !== 11'((k >= 1) ? ((k - 1) / HT) % VT
                                       : 0)) begin
          failures++;
          $display("FAIL scan_b k=%0d got pe=%b x=%0d y=%0d",
                   k, if_b.pix_en, if_b.x, if_b.y);
        end
        if (if_b.frame_start === 1'b1) begin
          fs_b++;
          checks++;
          if (abs_cyc - last_fs_b != HT * VT) begin
            failures++;
            $display("FAIL fs_period_b got=%0d want=%0d",
                     abs_cyc - last_fs_b, HT * VT);
          end
          last_fs_b = abs_cyc;
        end
      end
    end
  end

  int cur_k = 0;

  task automatic run_to(input int kk);
    repeat (kk - cur_k) @(negedge clk);
    cur_k = kk;
  endtask

  initial begin
    vec_t tbl[$];
    if_b.rgb_in = 8'h5A;
    tbl = '{
      '{1,    0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{3,    0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{4,    0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{5,    1,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{8,    1,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{9,    2,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{84,   20, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{85,   21, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{108,  26, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{109,  27, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{120,  29, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{121,  0,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{360,  29, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{361,  0,  3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1204, 0, 10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1205, 1, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1444, 0, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1445, 1, 12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1799, 29, 14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1800, 29, 14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1801, 0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0},
      '{1865, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 3'd7, 2'd3},
      '{1869, 17, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0},
      '{2705, 16, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 3'd7, 2'd3},
      '{2765, 1,  8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0},
      '{3989, 7,  3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 3'd7, 2'd3}
    };
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cur_k = 0;
    foreach (tbl[i]) begin
      if (!mode_ff && tbl[i].k > 1801) begin
        run_to(1802);
        mode_ff = 1'b1;
      end
      run_to(tbl[i].k);
      checks++;
      if (if_a.x !== 11'(tbl[i].x) || if_a.y !== 11'(tbl[i].y)
          || if_a.pix_en !== tbl[i].pe
          || if_a.frame_start !== tbl[i].fs
          || if_a.hsync !== tbl[i].hs
          || if_a.vsync !== tbl[i].vs
          || (tbl[i].chk_c && (if_a.vga_r !== tbl[i].r
                               || if_a.vga_g !== tbl[i].g
                               || if_a.vga_b !== tbl[i].b))) begin
        failures++;
        $display("FAIL vec k=%0d got x=%0d y=%0d pe=%b fs=%b hs=%b vs=%b rgb=%0d/%0d/%0d want x=%0d y=%0d pe=%b fs=%b hs=%b vs=%b rgb=%0d/%0d/%0d",
                 tbl[i].k, if_a.x, if_a.y, if_a.pix_en,
                 if_a.frame_start, if_a.hsync, if_a.vsync,
                 if_a.vga_r, if_a.vga_g, if_a.vga_b, tbl[i].x,
                 tbl[i].y, tbl[i].pe, tbl[i].fs, tbl[i].hs,
                 tbl[i].vs, tbl[i].r, tbl[i].g, tbl[i].b);
      end
    end
    // mid-frame reset: outputs drop to idle on the next clk
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (if_a.x !== 11'd0 || if_a.y !== 11'd0
        || if_a.pix_en !== 1'b0 || if_a.frame_start !== 1'b0
        || if_a.hsync !== 1'b1 || if_a.vsync !== 1'b1
        || if_a.vga_r !== 3'd0 || if_a.vga_g !== 3'd0
        || if_a.vga_b !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got x=%0d y=%0d pe=%b fs=%b hs=%b vs=%b rgb=%0d/%0d/%0d want 0 0 0 0 1 1 0/0/0",
               if_a.x, if_a.y, if_a.pix_en, if_a.frame_start,
               if_a.hsync, if_a.vsync, if_a.vga_r, if_a.vga_g,
               if_a.vga_b);
    end
    reset = 1'b0;
    repeat (1900) @(negedge clk);
    checks++;
    if (fs_a != 3) begin
      failures++;
      $display("FAIL fs_count_a got=%0d want=3", fs_a);
    end
    checks++;
    if (fs_b != 12) begin
      failures++;
      $display("FAIL fs_count_b got=%0d want=12", fs_b);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
